// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and word packing constants.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WR,
        CSUM,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 2;
    localparam int BYTE_W         = 8;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer: length byte, then big-endian byte pairs packed into words.
// Optional trailing XOR checksum and err port when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = BYTE_W * BYTES_PER_WORD,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic              err
`endif
);

    localparam int              REM_W    = ADDR_W + 1;
    localparam logic [REM_W-1:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [REM_W-1:0] remaining;
    logic             take;
    logic             launch;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    // An aborted cycle must not disturb the datapath even if the handshake completes.
    assign take   = rx_valid && rx_ready && !abort;
    assign launch = (state == IDLE) && start && !abort;

    assign mem_we    = (state == WR);
    assign busy      = (state != IDLE);
    assign load_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (launch) state_nxt = LEN;
            LEN:  if (take)   state_nxt = HI;
            HI:   if (take)   state_nxt = LO;
            LO:   if (take)   state_nxt = WR;
            WR: begin
                if (remaining != REM_W'(1)) begin
                    state_nxt = HI;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (take) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // rx_ready is a flop so the upstream handshake never sees a combinational path from rx_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_ready <= (state_nxt == LEN) || (state_nxt == HI) ||
                        (state_nxt == LO)  || (state_nxt == CSUM);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_waddr  <= BASE_ADDR;
            mem_wdata  <= '0;
            word_count <= '0;
            remaining  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        word_count <= '0;
                        mem_waddr  <= BASE_ADDR;
                    end
                end
                LEN: begin
                    if (take) begin
                        remaining <= (rx_data == 8'd0) ? FULL_LEN : REM_W'(rx_data);
                    end
                end
                HI: if (take) mem_wdata[DATA_W-1 -: BYTE_W] <= rx_data;
                LO: if (take) mem_wdata[BYTE_W-1:0]         <= rx_data;
                WR: begin
                    mem_waddr  <= mem_waddr + 1'b1;
                    word_count <= word_count + 1'b1;
                    remaining  <= remaining - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR covers only data bytes; the length byte is excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            if (launch) begin
                csum <= '0;
                err  <= 1'b0;
            end else if (take && ((state == HI) || (state == LO))) begin
                csum <= csum ^ rx_data;
            end else if (take && (state == CSUM)) begin
                err <= (csum != rx_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum loads run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic [8:0]  word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        err;
`endif

    int tests = 0;
    int fails = 0;

    int we_cnt      = 0;
    int done_cnt    = 0;
    int ready_in_wr = 0;
    int dbl_we      = 0;
    logic prev_we   = 1'b0;
    logic [15:0] tb_mem [256];

    int we_base;
    int done_base;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .load_done  (load_done),
        .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Memory image and strobe accounting, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            tb_mem[mem_waddr] = mem_wdata;
            we_cnt++;
            if (rx_ready) ready_in_wr++;
            if (prev_we)  dbl_we++;
        end
        if (load_done) done_cnt++;
        prev_we = mem_we;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_timeout", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        rx_valid = 1'b0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic snap();
        we_base   = we_cnt;
        done_base = done_cnt;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_busy",      {31'b0, busy},      32'd0);
        checkOutput("rst_rx_ready",  {31'b0, rx_ready},  32'd0);
        checkOutput("rst_mem_we",    {31'b0, mem_we},    32'd0);
        checkOutput("rst_load_done", {31'b0, load_done}, 32'd0);
        checkOutput("rst_waddr",     32'(mem_waddr),     32'h0);
        checkOutput("rst_wdata",     32'(mem_wdata),     32'h0);
        checkOutput("rst_count",     32'(word_count),    32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic three-word load.
        snap();
        pulseStart();
        checkOutput("t1_busy_len",  {31'b0, busy},     32'd1);
        checkOutput("t1_ready_len", {31'b0, rx_ready}, 32'd1);
        applyStimulus(8'h03);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitIdle(20);
        checkOutput("t1_mem0",  32'(tb_mem[0]),          32'hAABB);
        checkOutput("t1_mem1",  32'(tb_mem[1]),          32'h1122);
        checkOutput("t1_mem2",  32'(tb_mem[2]),          32'h3344);
        checkOutput("t1_we",    32'(we_cnt - we_base),   32'd3);
        checkOutput("t1_done",  32'(done_cnt - done_base), 32'd1);
        checkOutput("t1_count", 32'(word_count),         32'd3);
        checkOutput("t1_waddr", 32'(mem_waddr),          32'd3);

        // Full 256-word load selected by a zero length byte; address wraps back to 0.
        snap();
        pulseStart();
        applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(i[7:0]);
            applyStimulus(~i[7:0]);
        end
        waitIdle(20);
        checkOutput("t2_we",     32'(we_cnt - we_base),   32'd256);
        checkOutput("t2_count",  32'(word_count),         32'd256);
        checkOutput("t2_waddr",  32'(mem_waddr),          32'd0);
        checkOutput("t2_mem00",  32'(tb_mem[0]),          32'h00FF);
        checkOutput("t2_mem80",  32'(tb_mem[8'h80]),      32'h807F);
        checkOutput("t2_memff",  32'(tb_mem[8'hFF]),      32'hFF00);
        checkOutput("t2_done",   32'(done_cnt - done_base), 32'd1);

        // Gappy rx_valid must not lose or duplicate bytes.
        snap();
        pulseStart();
        begin
            logic [7:0] seq [5];
            seq = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
            for (int k = 0; k < 5; k++) begin
                rx_valid = 1'b0;
                rx_data  = 8'h5A;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                applyStimulus(seq[k]);
            end
        end
        waitIdle(20);
        checkOutput("t3_mem0",  32'(tb_mem[0]),          32'hDEAD);
        checkOutput("t3_mem1",  32'(tb_mem[1]),          32'hBEEF);
        checkOutput("t3_we",    32'(we_cnt - we_base),   32'd2);
        checkOutput("t3_count", 32'(word_count),         32'd2);

        // Abort after the high byte of word 2.
        snap();
        pulseStart();
        applyStimulus(8'h03);
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        rx_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        checkOutput("t4_busy",  {31'b0, busy},           32'd0);
        checkOutput("t4_count", 32'(word_count),         32'd1);
        checkOutput("t4_we",    32'(we_cnt - we_base),   32'd1);
        checkOutput("t4_mem0",  32'(tb_mem[0]),          32'h5566);
        checkOutput("t4_mem1",  32'(tb_mem[1]),          32'hBEEF);
        repeat (3) @(negedge clk);
        checkOutput("t4_done",  32'(done_cnt - done_base), 32'd0);

        // Asynchronous reset in the middle of a word.
        pulseStart();
        applyStimulus(8'h02);
        applyStimulus(8'h12);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("t4r_busy",  {31'b0, busy},     32'd0);
        checkOutput("t4r_ready", {31'b0, rx_ready}, 32'd0);
        checkOutput("t4r_wdata", 32'(mem_wdata),    32'h0);
        checkOutput("t4r_waddr", 32'(mem_waddr),    32'h0);
        checkOutput("t4r_we",    {31'b0, mem_we},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // start during a load is ignored; start with abort in IDLE does nothing.
        snap();
        pulseStart();
        applyStimulus(8'h02);
        applyStimulus(8'hAB);
        applyStimulus(8'hCD);
        rx_valid = 1'b0;
        pulseStart();
        checkOutput("t5_busy_mid", {31'b0, busy}, 32'd1);
        applyStimulus(8'hEF);
        applyStimulus(8'h01);
        waitIdle(20);
        checkOutput("t5_mem0",  32'(tb_mem[0]),            32'hABCD);
        checkOutput("t5_mem1",  32'(tb_mem[1]),            32'hEF01);
        checkOutput("t5_count", 32'(word_count),           32'd2);
        checkOutput("t5_done",  32'(done_cnt - done_base), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t5_sa_busy",  {31'b0, busy},     32'd0);
        checkOutput("t5_sa_ready", {31'b0, rx_ready}, 32'd0);
        checkOutput("t5_sa_count", 32'(word_count),   32'd2);
        checkOutput("t5_sa_waddr", 32'(mem_waddr),    32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: 12^34 = 26, so 27 flags an error.
        snap();
        pulseStart();
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h27);
        waitIdle(20);
        checkOutput("t6_err_bad",  {31'b0, err},             32'd1);
        checkOutput("t6_done_bad", 32'(done_cnt - done_base), 32'd1);
        checkOutput("t6_mem0",     32'(tb_mem[0]),            32'h1234);

        snap();
        pulseStart();
        checkOutput("t6_err_clr", {31'b0, err}, 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h26);
        waitIdle(20);
        checkOutput("t6_err_good",  {31'b0, err},             32'd0);
        checkOutput("t6_done_good", 32'(done_cnt - done_base), 32'd1);
`endif

        checkOutput("we_single_cycle", 32'(dbl_we),      32'd0);
        checkOutput("ready_low_in_wr", 32'(ready_in_wr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
